// File: rtl/axi_w_last_gen.sv
// Turns a raw beat stream into an AXI W stream by counting beats against
// queued AWLEN values and stamping the last flag on the final beat of each burst.
module axi_w_last_gen #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned USER_WIDTH     = 1,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned LEN_FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  len_valid_i,
  input  logic [7:0]            len_i,
  output logic                  len_ready_o,
  input  logic                  data_valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [STRB_WIDTH-1:0] strb_i,
  input  logic [USER_WIDTH-1:0] user_i,
  output logic                  data_ready_o,
  output logic                  master_valid_o,
  output logic [DATA_WIDTH-1:0] master_data_o,
  output logic [STRB_WIDTH-1:0] master_strb_o,
  output logic [USER_WIDTH-1:0] master_user_o,
  output logic                  master_last_o,
  input  logic                  master_ready_i,
  output logic                  busy_o
);

  localparam int unsigned PTR_W = (LEN_FIFO_DEPTH > 1) ? $clog2(LEN_FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(LEN_FIFO_DEPTH + 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_cnt;
  logic [7:0]            w_cnt_nxt;

  logic [7:0]            r_mem [LEN_FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [OCC_W-1:0]      r_occ;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [7:0]            w_head;

  logic                  r_mvalid;
  logic [DATA_WIDTH-1:0] r_mdata;
  logic [STRB_WIDTH-1:0] r_mstrb;
  logic [USER_WIDTH-1:0] r_muser;
  logic                  r_mlast;
  logic                  w_data_hs;

  // Length queue: full/empty come from the occupancy count so that pointer
  // equality is never ambiguous.
  assign w_empty     = (r_occ == '0);
  assign len_ready_o = (r_occ != OCC_W'(LEN_FIFO_DEPTH));
  assign w_push      = len_valid_i && len_ready_o;
  assign w_head      = r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= len_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign data_ready_o = (r_state == ST_BURST) && (!r_mvalid || master_ready_i);
  assign w_data_hs    = data_valid_i && data_ready_o;

  // The final beat of a burst reloads the counter from the queue on the same
  // edge, so consecutive bursts run without an idle cycle between them.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_cnt_nxt   = w_head;
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        if (w_data_hs) begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 8'd1;
          end else if (!w_empty) begin
            w_pop     = 1'b1;
            w_cnt_nxt = w_head;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
      r_mstrb  <= '0;
      r_muser  <= '0;
      r_mlast  <= 1'b0;
    end else if (w_data_hs) begin
      r_mvalid <= 1'b1;
      r_mdata  <= data_i;
      r_mstrb  <= strb_i;
      r_muser  <= user_i;
      r_mlast  <= (r_cnt == '0);
    end else if (r_mvalid && master_ready_i) begin
      r_mvalid <= 1'b0;
    end
  end

  assign master_valid_o = r_mvalid;
  assign master_data_o  = r_mdata;
  assign master_strb_o  = r_mstrb;
  assign master_user_o  = r_muser;
  assign master_last_o  = r_mlast;

  assign busy_o = (r_state == ST_BURST) || !w_empty || r_mvalid;

endmodule

// File: tb/tb_axi_w_last_gen.sv
// Directed bench for axi_w_last_gen: single beat, back-to-back bursts,
// backpressure, queue full, 256-beat burst and mid-burst reset.
module tb_axi_w_last_gen;

  localparam int DW    = 64;
  localparam int UW    = 1;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          len_valid_i;
  logic [7:0]    len_i;
  logic          len_ready_o;
  logic          data_valid_i;
  logic [DW-1:0] data_i;
  logic [SW-1:0] strb_i;
  logic [UW-1:0] user_i;
  logic          data_ready_o;
  logic          master_valid_o;
  logic [DW-1:0] master_data_o;
  logic [SW-1:0] master_strb_o;
  logic [UW-1:0] master_user_o;
  logic          master_last_o;
  logic          master_ready_i;
  logic          busy_o;

  axi_w_last_gen #(
    .DATA_WIDTH(DW),
    .USER_WIDTH(UW),
    .STRB_WIDTH(SW),
    .LEN_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .len_valid_i(len_valid_i),
    .len_i(len_i),
    .len_ready_o(len_ready_o),
    .data_valid_i(data_valid_i),
    .data_i(data_i),
    .strb_i(strb_i),
    .user_i(user_i),
    .data_ready_o(data_ready_o),
    .master_valid_o(master_valid_o),
    .master_data_o(master_data_o),
    .master_strb_o(master_strb_o),
    .master_user_o(master_user_o),
    .master_last_o(master_last_o),
    .master_ready_i(master_ready_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int vcnt    = 0;

  logic [DW-1:0] mon_data [$];
  bit            mon_last [$];
  int            mon_cyc  [$];

  bit            stall_prev = 1'b0;
  logic [127:0]  stall_snap = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: inputs move just after the rising edge, so the negedge
  // view is exactly what the next rising edge will see.
  always @(negedge clk) begin
    if (!rst_i && master_valid_o) begin
      vcnt <= vcnt + 1;
      if (master_ready_i) begin
        mon_data.push_back(master_data_o);
        mon_last.push_back(master_last_o);
        mon_cyc.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_i) begin
      stall_prev <= 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_hold",
              {53'd0, master_valid_o, master_data_o, master_strb_o, master_user_o, master_last_o},
              stall_snap);
      end
      stall_prev <= master_valid_o && !master_ready_i;
      stall_snap <= {53'd0, master_valid_o, master_data_o, master_strb_o, master_user_o, master_last_o};
    end
  end

  task automatic push_len(input logic [7:0] l);
    int  c    = 0;
    bit  done = 1'b0;
    len_valid_i = 1'b1;
    len_i       = l;
    while (!done && c < 50) begin
      @(negedge clk);
      if (len_ready_o) done = 1'b1;
      @(posedge clk); #1;
      c++;
    end
    len_valid_i = 1'b0;
    if (!done) check("push_timeout", 0, 1);
  endtask

  task automatic run_phase(input int nbeats, input bit toggle, input int max_cyc,
                           input logic [DW-1:0] base);
    int i     = 0;
    int c     = 0;
    int start = mon_data.size();
    bit rdy   = 1'b1;
    bit hs;
    @(posedge clk); #1;
    while ((i < nbeats || (mon_data.size() - start) < nbeats) && c < max_cyc) begin
      data_valid_i   = (i < nbeats);
      data_i         = base + DW'(i);
      strb_i         = SW'(8'hFF ^ i[7:0]);
      user_i         = UW'(i[0]);
      master_ready_i = toggle ? rdy : 1'b1;
      rdy            = ~rdy;
      @(negedge clk);
      hs = data_valid_i && data_ready_o;
      @(posedge clk); #1;
      if (hs) i++;
      c++;
    end
    data_valid_i   = 1'b0;
    master_ready_i = 1'b1;
    if (c >= max_cyc) check("phase_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_mon();
    mon_data.delete();
    mon_last.delete();
    mon_cyc.delete();
  endtask

  function automatic int data_errs(input logic [DW-1:0] base, input int n);
    int e = 0;
    for (int k = 0; k < n && k < mon_data.size(); k++) begin
      if (mon_data[k] !== base + DW'(k)) e++;
    end
    return e;
  endfunction

  initial begin
    int          acc;
    int          lasts;
    logic [15:0] lv;

    rst_i          = 1'b1;
    len_valid_i    = 1'b0;
    len_i          = '0;
    data_valid_i   = 1'b0;
    data_i         = '0;
    strb_i         = '0;
    user_i         = '0;
    master_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mvalid", master_valid_o, 0);
    check("rst_mlast", master_last_o, 0);
    check("rst_mdata", {master_data_o, master_strb_o, master_user_o}, 0);
    check("rst_len_ready", len_ready_o, 1);
    check("rst_data_ready", data_ready_o, 0);
    check("rst_busy", busy_o, 0);
    rst_i = 1'b0;
    idle(1);

    // single beat
    clear_mon();
    vcnt = 0;
    push_len(8'd0);
    run_phase(1, 1'b0, 20, 64'hD0);
    idle(3);
    check("single_n", mon_data.size(), 1);
    if (mon_data.size() >= 1) begin
      check("single_data", mon_data[0], 64'hD0);
      check("single_last", mon_last[0], 1);
    end
    check("single_vcycles", vcnt, 1);
    check("single_busy", busy_o, 0);
    check("single_dready", data_ready_o, 0);

    // back-to-back bursts of 4 and 2 beats
    clear_mon();
    push_len(8'd3);
    push_len(8'd1);
    run_phase(6, 1'b0, 40, 64'h100);
    idle(2);
    check("b2b_n", mon_data.size(), 6);
    check("b2b_data", data_errs(64'h100, 6), 0);
    lv = '0;
    for (int k = 0; k < mon_last.size() && k < 16; k++) lv[k] = mon_last[k];
    check("b2b_last", lv, 16'b10_1000);
    if (mon_cyc.size() == 6) check("b2b_nobubble", mon_cyc[5] - mon_cyc[0], 5);

    // backpressure with toggling ready
    clear_mon();
    push_len(8'd7);
    run_phase(8, 1'b1, 60, 64'h200);
    idle(2);
    check("bp_n", mon_data.size(), 8);
    check("bp_data", data_errs(64'h200, 8), 0);
    lv = '0;
    for (int k = 0; k < mon_last.size() && k < 16; k++) lv[k] = mon_last[k];
    check("bp_last", lv, 16'h0080);
    check("bp_busy", busy_o, 0);

    // queue full: the first length is popped straight into the counter
    clear_mon();
    acc         = 0;
    len_valid_i = 1'b1;
    len_i       = 8'd0;
    repeat (DEPTH + 3) begin
      @(negedge clk);
      if (len_ready_o) acc++;
      @(posedge clk); #1;
    end
    len_valid_i = 1'b0;
    check("full_accepted", acc, DEPTH + 1);
    check("full_len_ready", len_ready_o, 0);
    run_phase(1, 1'b0, 20, 64'h300);
    check("full_pop_ready", len_ready_o, 1);
    run_phase(DEPTH, 1'b0, 40, 64'h301);
    idle(3);
    check("full_n", mon_data.size(), DEPTH + 1);
    lasts = 0;
    foreach (mon_last[k]) if (mon_last[k]) lasts++;
    check("full_lasts", lasts, DEPTH + 1);
    check("full_busy", busy_o, 0);

    // 256-beat burst
    clear_mon();
    push_len(8'd255);
    run_phase(256, 1'b0, 400, 64'h1000);
    idle(2);
    check("max_n", mon_data.size(), 256);
    check("max_data", data_errs(64'h1000, 256), 0);
    lasts = 0;
    foreach (mon_last[k]) if (mon_last[k]) lasts++;
    check("max_lastcount", lasts, 1);
    if (mon_last.size() == 256) check("max_last256", mon_last[255], 1);
    check("max_cnt", dut.r_cnt, 0);
    check("max_busy", busy_o, 0);

    // reset mid-burst with the output register stalled
    clear_mon();
    push_len(8'd3);
    push_len(8'd2);
    master_ready_i = 1'b0;
    data_valid_i   = 1'b1;
    data_i         = 64'hAA;
    idle(4);
    check("mid_pre_valid", master_valid_o, 1);
    rst_i = 1'b1;
    idle(2);
    check("mid_rst_valid", master_valid_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_len_ready", len_ready_o, 1);
    check("mid_rst_dready", data_ready_o, 0);
    rst_i          = 1'b0;
    master_ready_i = 1'b1;
    idle(1);
    check("mid_post_valid", master_valid_o, 0);
    idle(2);
    check("mid_post_busy", busy_o, 0);
    data_valid_i = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_w_last_gen.md
AXI_W_LAST_GEN -- requirements
Module: axi_w_last_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: W data width in bits.
REQ-002 SHALL have parameter USER_WIDTH, default 1: W user width in bits.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8: strobe width.
REQ-004 SHALL have parameter LEN_FIFO_DEPTH, default 4: burst-length queue entries, power of two, at least 2.
REQ-005 SHALL have port clk_i, input, 1: the single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have ports len_valid_i (input, 1), len_i (input, 8, AXI AWLEN, beats minus one) and len_ready_o (output, 1): burst-length push channel.
REQ-008 SHALL have ports data_valid_i (input, 1), data_i (input, DATA_WIDTH), strb_i (input, STRB_WIDTH), user_i (input, USER_WIDTH) and data_ready_o (output, 1): raw beat stream with no last.
REQ-009 SHALL have ports master_valid_o, master_data_o, master_strb_o, master_user_o and master_last_o (outputs) plus master_ready_i (input): AXI W stream that feeds the W-channel buffer.
REQ-010 SHALL have port busy_o, output, 1: high while in BURST or while the queue or the output register holds content.

Function
REQ-011 SHALL push len_i into an internal FIFO on len_valid_i && len_ready_o, with len_ready_o = !queue_full (registered status, no combinational dependence on pop).
REQ-012 SHALL implement FSM states IDLE and BURST, plus an 8-bit beat counter cnt.
REQ-013 In IDLE with queue non-empty, SHALL pop one entry, load cnt = entry and enter BURST on the next edge; data_ready_o SHALL be 0 in IDLE.
REQ-014 SHALL drive data_ready_o = (state==BURST) && (!master_valid_o || master_ready_i).
REQ-015 SHALL, on each data handshake, load the output register with data/strb/user and master_last_o = (cnt==0), set master_valid_o = 1 the next cycle (latency 1 cycle), and decrement cnt when cnt != 0.
REQ-016 SHALL, on handshake of the beat with cnt==0, pop the next queue entry into cnt and stay in BURST the same edge if the queue is non-empty (zero-bubble back-to-back bursts); otherwise go to IDLE.
REQ-017 SHALL, when master_ready_i && master_valid_o and no new beat is accepted, clear master_valid_o on the next edge.
REQ-018 SHALL hold all master_* outputs stable while master_valid_o && !master_ready_i.
REQ-019 SHALL sustain one beat per cycle when master_ready_i stays 1.
REQ-020 SHALL allow a push and a pop on the same cycle; queue occupancy is then unchanged, and a push when full is ignored because len_ready_o = 0.
REQ-021 SHALL treat len_i = 0 as a single beat with master_last_o = 1, and len_i = 255 as 256 beats without counter wrap.
REQ-022 SHALL make queue pointers wrap modulo LEN_FIFO_DEPTH, with a separate full/empty indication (occupancy counter).

Reset
REQ-023 SHALL, while rst_i = 1 at a clock edge, set state = IDLE, cnt = 0, queue empty, master_valid_o = 0, master_last_o = 0, master_data_o/strb/user = 0, len_ready_o = 1 after the reset edge, data_ready_o = 0 and busy_o = 0.
REQ-024 SHALL discard any in-flight burst and queued lengths on reset asserted mid-operation; no beat is emitted in the cycle after reset.

Verification
REQ-025 Reset: hold rst_i for 2 cycles mid-burst with master_valid_o = 1 -> after the edge master_valid_o = 0, busy_o = 0, len_ready_o = 1.
REQ-026 Single beat: push len 0, supply 1 beat D0, master_ready_i = 1 -> master_valid_o for exactly 1 cycle, data D0, master_last_o = 1, state IDLE afterwards.
REQ-027 Back-to-back: push lens 3 and 1, stream 6 beats continuously, master_ready_i = 1 -> 6 consecutive output cycles, last = 1 on beats 4 and 6 only, no bubble.
REQ-028 Backpressure: len 7, master_ready_i toggling 1/0 each cycle -> 8 beats in order, outputs stable across stall cycles, last on beat 8 only.
REQ-029 Queue full: push LEN_FIFO_DEPTH+1 lengths with no data -> len_ready_o = 0 after the last accepted push, the extra push is not taken, and a pop restores len_ready_o = 1 the next cycle.
REQ-030 Max burst: len 255 -> exactly 256 beats, last only on beat 256, cnt = 0 at the end.
